// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: rings on a rising edge of the alarm match, supports
// a bounded number of snoozes, auto-stops after a ring timeout and flags it.
module alarm_ring_ctrl #(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic       clk_1hz,
   input  logic       cr,
   input  logic       en,
   input  logic       match,
   input  logic       stop,
   input  logic       snooze,
   output logic       beep,
   output logic [1:0] state,
   output logic [1:0] snooze_cnt,
   output logic       missed
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RING   = 2'b01,
      SNOOZE = 2'b10
   } state_t;

   localparam logic [8:0] RING_LAST   = 9'(RING_SEC - 1);
   localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SEC - 1);
   localparam logic [1:0] CNT_MAX     = 2'(MAX_SNOOZE);

   state_t     state_q, state_d;
   logic [8:0] timer_q, timer_d;
   logic [1:0] cnt_q, cnt_d;
   logic       beep_q, beep_d;
   logic       missed_q, missed_d;
   logic       match_q, match_d;
   logic       trigger;

   assign trigger = match & ~match_q;

   // NOTE: every variable gets a default before the case so no path can
   // leave one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      cnt_d    = cnt_q;
      beep_d   = beep_q;
      missed_d = missed_q;
      match_d  = match;

      if (!en) begin
         state_d = IDLE;
         timer_d = '0;
         cnt_d   = '0;
         beep_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               timer_d = '0;
               beep_d  = 1'b0;
               if (stop) missed_d = 1'b0;
               if (trigger) begin
                  state_d = RING;
                  cnt_d   = '0;
                  beep_d  = 1'b1;
               end
            end
            RING: begin
               if (stop) begin
                  state_d = IDLE;
                  timer_d = '0;
                  beep_d  = 1'b0;
               end else if (timer_q == RING_LAST) begin
                  state_d  = IDLE;
                  timer_d  = '0;
                  beep_d   = 1'b0;
                  missed_d = 1'b1;
               end else if (snooze && (cnt_q < CNT_MAX)) begin
                  state_d = SNOOZE;
                  timer_d = '0;
                  beep_d  = 1'b0;
                  cnt_d   = cnt_q + 2'd1;
               end else begin
                  timer_d = timer_q + 9'd1;
                  beep_d  = ~beep_q;
               end
            end
            SNOOZE: begin
               beep_d = 1'b0;
               if (stop) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else if (timer_q == SNOOZE_LAST) begin
                  state_d = RING;
                  timer_d = '0;
                  beep_d  = 1'b1;
               end else begin
                  timer_d = timer_q + 9'd1;
               end
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
               beep_d  = 1'b0;
            end
         endcase
      end
   end

   // NOTE: match_q resets to 1 so a match already high at reset release is
   // not mistaken for a fresh rising edge.
   always_ff @(posedge clk_1hz) begin
      if (!cr) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         cnt_q    <= '0;
         beep_q   <= 1'b0;
         missed_q <= 1'b0;
         match_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         cnt_q    <= cnt_d;
         beep_q   <= beep_d;
         missed_q <= missed_d;
         match_q  <= match_d;
      end
   end

   assign state      = state_q;
   assign beep       = beep_q;
   assign snooze_cnt = cnt_q;
   assign missed     = missed_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_alarm_ring_ctrl;

   localparam int RING_SEC   = 60;
   localparam int SNOOZE_SEC = 300;
   localparam int MAX_SNOOZE = 3;

   logic       clk_1hz = 1'b0;
   logic       cr, en, match, stop, snooze;
   logic       beep, missed;
   logic [1:0] state, snooze_cnt;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   alarm_ring_ctrl #(
      .RING_SEC  (RING_SEC),
      .SNOOZE_SEC(SNOOZE_SEC),
      .MAX_SNOOZE(MAX_SNOOZE)
   ) dut (
      .clk_1hz   (clk_1hz),
      .cr        (cr),
      .en        (en),
      .match     (match),
      .stop      (stop),
      .snooze    (snooze),
      .beep      (beep),
      .state     (state),
      .snooze_cnt(snooze_cnt),
      .missed    (missed)
   );

   always #5 clk_1hz = ~clk_1hz;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Behavioural model: mode 0 idle, 1 ringing, 2 snoozing; m_el counts
   // cycles spent in the current mode, beep is derived from its parity.
   int m_mode = 0, m_el = 0, m_cnt = 0, m_missed = 0, m_prev = 1;

   always @(posedge clk_1hz) begin
      bit trig;
      trig = match && (m_prev == 0);
      if (!cr) begin
         m_mode = 0; m_el = 0; m_cnt = 0; m_missed = 0; m_prev = 1;
      end else begin
         m_prev = int'(match);
         if (!en) begin
            m_mode = 0; m_el = 0; m_cnt = 0;
         end else if (m_mode == 1) begin
            if (stop) begin
               m_mode = 0; m_el = 0;
            end else if (m_el + 1 == RING_SEC) begin
               m_mode = 0; m_el = 0; m_missed = 1;
            end else if (snooze && m_cnt < MAX_SNOOZE) begin
               m_mode = 2; m_el = 0; m_cnt = m_cnt + 1;
            end else begin
               m_el = m_el + 1;
            end
         end else if (m_mode == 2) begin
            if (stop) begin
               m_mode = 0; m_el = 0;
            end else if (m_el + 1 == SNOOZE_SEC) begin
               m_mode = 1; m_el = 0;
            end else begin
               m_el = m_el + 1;
            end
         end else begin
            if (stop) m_missed = 0;
            if (trig) begin
               m_mode = 1; m_el = 0; m_cnt = 0;
            end
         end
      end
   end

   always @(posedge clk_1hz) begin
      logic [1:0] e_state;
      logic       e_beep;
      #1;
      if (chk_on) begin
         e_state = 2'(m_mode);
         e_beep  = (m_mode == 1) && (m_el % 2 == 0);
         n_vec++;
         if (state !== e_state || beep !== e_beep ||
             snooze_cnt !== 2'(m_cnt) || missed !== 1'(m_missed)) begin
            n_err++;
            $display("FAIL model_cmp t=%0t state=%0d exp=%0d beep=%0b exp=%0b cnt=%0d exp=%0d missed=%0b exp=%0b",
                     $time, state, e_state, beep, e_beep, snooze_cnt, m_cnt, missed, m_missed);
         end
      end
   end

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_1hz);
   endtask

   initial begin
      cr = 1'b0; en = 1'b1; match = 1'b0; stop = 1'b0; snooze = 1'b0;
      tick(1);
      chk_on = 1'b1;
      check("rst_state", state, 0);
      check("rst_beep", beep, 0);
      check("rst_missed", missed, 0);
      cr = 1'b1;
      tick(9);
      check("idle_no_match", state, 0);

      // Ring with no keys until timeout.
      match = 1'b1;
      tick(1);
      check("ring_entry_state", state, 1);
      check("ring_entry_beep", beep, 1);
      tick(1);
      check("ring_beep_2", beep, 0);
      tick(1);
      check("ring_beep_3", beep, 1);
      tick(57);
      check("ring_last_cycle", state, 1);
      tick(1);
      check("timeout_state", state, 0);
      check("timeout_missed", missed, 1);

      match = 1'b0; stop = 1'b1;
      tick(1);
      stop = 1'b0;
      check("idle_stop_clears_missed", missed, 0);

      // Snooze at ring cycle 5, then return after the snooze interval.
      match = 1'b1;
      tick(1);
      check("ring2_entry", state, 1);
      tick(4);
      snooze = 1'b1;
      tick(1);
      snooze = 1'b0;
      check("snooze_state", state, 2);
      check("snooze_cnt_1", snooze_cnt, 1);
      check("snooze_beep", beep, 0);
      tick(299);
      check("snooze_last_cycle", state, 2);
      tick(1);
      check("snooze_return_state", state, 1);
      check("snooze_return_beep", beep, 1);

      for (int k = 2; k <= 3; k++) begin
         snooze = 1'b1;
         tick(1);
         snooze = 1'b0;
         check("snooze_cnt_k", snooze_cnt, 9'(k));
         tick(300);
         check("snooze_k_return", state, 1);
      end
      snooze = 1'b1;
      tick(1);
      snooze = 1'b0;
      check("snooze_sat_state", state, 1);
      check("snooze_sat_cnt", snooze_cnt, 3);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      check("stop_after_sat", state, 0);
      check("stop_missed_clear", missed, 0);

      // Stop and snooze together: stop wins.
      match = 1'b0;
      tick(1);
      match = 1'b1;
      tick(1);
      check("retrigger_cnt_clear", snooze_cnt, 0);
      stop = 1'b1; snooze = 1'b1;
      tick(1);
      stop = 1'b0; snooze = 1'b0;
      check("stop_snooze_state", state, 0);
      check("stop_snooze_cnt", snooze_cnt, 0);

      // Match held through reset release must not ring.
      cr = 1'b0;
      tick(2);
      cr = 1'b1;
      tick(3);
      check("match_held_reset", state, 0);
      match = 1'b0;
      tick(1);
      match = 1'b1;
      tick(1);
      check("match_rise_after_reset", state, 1);

      // Drop en during snooze.
      snooze = 1'b1;
      tick(1);
      snooze = 1'b0;
      check("pre_en_snooze", state, 2);
      en = 1'b0;
      tick(1);
      en = 1'b1;
      check("en_drop_state", state, 0);
      check("en_drop_cnt", snooze_cnt, 0);
      tick(3);
      check("en_back_no_ring", state, 0);

      // Reset mid-ring overrides keys and en.
      match = 1'b0;
      tick(1);
      match = 1'b1;
      tick(1);
      check("ring_before_reset", state, 1);
      cr = 1'b0; stop = 1'b1; snooze = 1'b1; en = 1'b0;
      tick(1);
      check("reset_mid_ring_state", state, 0);
      check("reset_mid_ring_beep", beep, 0);
      cr = 1'b1; stop = 1'b0; snooze = 1'b0; en = 1'b1;

      for (int i = 0; i < 20000; i++) begin
         cr     = ($urandom_range(0, 1999) != 0);
         en     = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 39) == 0) match = ~match;
         stop   = ($urandom_range(0, 149) == 0);
         snooze = ($urandom_range(0, 9) == 0);
         tick(1);
      end

      chk_on = 1'b0;
      tick(1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alarm_ring_ctrl.md
ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 Parameter RING_SEC, default 60, ring duration in clk_1hz cycles before auto-stop.
REQ-002 Parameter SNOOZE_SEC, default 300, snooze interval in clk_1hz cycles.
REQ-003 Parameter MAX_SNOOZE, default 3, maximum snoozes per alarm event.
REQ-004 clk_1hz  input  1  sole clock; all state changes on its rising edge.
REQ-005 cr  input  1  synchronous reset, active-low.
REQ-006 en  input  1  alarm enable; 0 forces the block idle.
REQ-007 match  input  1  level from the time/alarm comparator; high for the whole matching minute.
REQ-008 stop  input  1  debounced one-cycle pulse; silences the alarm.
REQ-009 snooze  input  1  debounced one-cycle pulse; requests a snooze.
REQ-010 beep  output  1  buzzer drive, registered.
REQ-011 state  output  2  current state: IDLE=00, RING=01, SNOOZE=10; 11 unused.
REQ-012 snooze_cnt  output  2  snoozes taken in the current alarm event.
REQ-013 missed  output  1  sticky flag: an alarm event ended by timeout.

Function
REQ-014 A 1-bit register match_q SHALL hold match from the previous cycle; trigger = match & ~match_q.
REQ-015 The timer SHALL be 9 bits, count up by 1 per cycle in RING/SNOOZE, and be cleared on every state entry.
REQ-016 Key priority in every state SHALL be: en=0 > stop > timeout/expiry > snooze.
REQ-017 en=0 SHALL force state IDLE, timer 0, snooze_cnt 0, beep 0 on the next edge; missed is held; match_q keeps tracking.
REQ-018 IDLE: trigger with en=1 SHALL go to RING, clear snooze_cnt; stop and snooze SHALL be ignored except that stop clears missed.
REQ-019 RING: beep SHALL be 1 on the first RING cycle and toggle each cycle thereafter (0.5 Hz pattern).
REQ-020 RING: stop SHALL go to IDLE with beep 0 on the next cycle; missed unchanged.
REQ-021 RING: timer == RING_SEC-1 without stop SHALL go to IDLE and set missed.
REQ-022 RING: snooze with snooze_cnt < MAX_SNOOZE SHALL go to SNOOZE and increment snooze_cnt; with snooze_cnt == MAX_SNOOZE it SHALL be ignored.
REQ-023 SNOOZE: beep SHALL be 0; stop SHALL go to IDLE; timer == SNOOZE_SEC-1 SHALL return to RING (timer cleared, beep 1).
REQ-024 Trigger while in RING or SNOOZE SHALL be ignored (no restart, no counter change).
REQ-025 snooze_cnt SHALL saturate at MAX_SNOOZE and never wrap.
REQ-026 State 11 SHALL be treated as IDLE on the next edge.

Reset
REQ-027 cr=0 at a rising edge SHALL set state IDLE, timer 0, snooze_cnt 0, beep 0, missed 0, match_q 1.
REQ-028 match_q reset value 1 SHALL prevent ringing when match is already high on reset release; ringing resumes only after the next true rising edge of match.
REQ-029 Reset asserted mid-RING or mid-SNOOZE SHALL take effect on that edge regardless of keys or en.

Verification
REQ-030 Reset, en=1, raise match at cycle 10 -> state=01 and beep=1 at cycle 11, beep toggles 1,0,1,...; no keys -> state=00 and missed=1 after 60 RING cycles.
REQ-031 Ring, pulse snooze at RING cycle 5 -> state=10, snooze_cnt=1, beep=0; after 300 cycles -> state=01, beep=1.
REQ-032 Snooze 3 times, then pulse snooze in the 4th RING -> remains 01, snooze_cnt=3; stop -> 00 and missed=0.
REQ-033 In RING, stop and snooze asserted in the same cycle -> state=00, snooze_cnt unchanged.
REQ-034 Hold match=1 through reset release -> state stays 00; drop match then raise it -> state=01.
REQ-035 In SNOOZE, drop en for 1 cycle -> state=00, snooze_cnt=0; re-raise en with match still high -> no ring.
